core_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32 core datapath. Drives one instruction at a time through fetch, decode/execute, optional memory access and writeback, using valid/ready handshakes to the instruction-fetch port and the load/store port. Gates register-file, CSR and PC write enables so that architectural state changes only in the writeback cycle. Sits between the instruction decoder outputs and the IFU/LSU bus masters.

---
 rtl/core_ctrl_pkg.sv | 29 ++
 rtl/core_seq_perf.sv | 41 ++++
 rtl/core_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_core_seq_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the RV32 multi-cycle sequencer: state encoding,
// timeout default and performance counter widths.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH_REQ  = 3'd1,
    ST_FETCH_WAIT = 3'd2,
    ST_EXEC       = 3'd3,
    ST_MEM_REQ    = 3'd4,
    ST_MEM_WAIT   = 3'd5,
    ST_WB         = 3'd6,
    ST_HALT       = 3'd7
  } ctrl_state_e;

  localparam int TIMEOUT_CYCLES_DEF = 255;

  localparam int PERF_CYCLE_W   = 64;
  localparam int PERF_INSTRET_W = 64;
  localparam int PERF_STALL_W   = 32;

  // Width of a counter that must hold 0..cycles; never narrower than 1 bit.
  function automatic int to_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/core_seq_perf.sv
// Optional sequencer performance counters: active cycles, retired
// instructions and saturating memory-stall cycles.
module core_seq_perf
  import core_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  ctrl_state_e               state,
  input  logic                      wb_pulse,
  output logic [PERF_CYCLE_W-1:0]   perf_cycle,
  output logic [PERF_INSTRET_W-1:0] perf_instret,
  output logic [PERF_STALL_W-1:0]   perf_mem_stall
);

  logic active;
  logic in_mem;

  always_comb begin
    active = (state != ST_IDLE) && (state != ST_HALT);
    in_mem = (state == ST_MEM_REQ) || (state == ST_MEM_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycle     <= '0;
      perf_instret   <= '0;
      perf_mem_stall <= '0;
    end else begin
      if (active) begin
        perf_cycle <= perf_cycle + PERF_CYCLE_W'(1);
      end
      if (wb_pulse) begin
        perf_instret <= perf_instret + PERF_INSTRET_W'(1);
      end
      if (in_mem && (perf_mem_stall != '1)) begin
        perf_mem_stall <= perf_mem_stall + PERF_STALL_W'(1);
      end
    end
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// RV32 multi-cycle sequencer: fetch, execute, memory and writeback control
// with bus-response timeouts. Define CTRL_PERF_CNT_EN for performance counters.
module core_seq_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      ifu_req_valid,
  input  logic                      ifu_req_ready,
  input  logic                      ifu_resp_valid,
  input  logic                      ifu_resp_err,
  output logic                      inst_latch_en,
  input  logic                      dec_mem_rd_en,
  input  logic                      dec_mem_wr_en,
  input  logic                      dec_w_en,
  input  logic                      dec_w_csr_en,
  input  logic                      dec_halt,
  output logic                      lsu_req_valid,
  input  logic                      lsu_req_ready,
  input  logic                      lsu_resp_valid,
  input  logic                      lsu_resp_err,
  output logic                      rf_we,
  output logic                      csr_we,
  output logic                      pc_we,
  output logic                      halted,
  output logic                      bus_err,
  output logic [2:0]                state_o,
  output logic [PERF_CYCLE_W-1:0]   perf_cycle,
  output logic [PERF_INSTRET_W-1:0] perf_instret,
  output logic [PERF_STALL_W-1:0]   perf_mem_stall
);

  localparam int TO_W = to_width(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  ctrl_state_e     state;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_nxt;
  logic            to_expired;
  logic            resp_valid;
  logic            resp_err;

  // Both wait states share one counter and one response path.
  always_comb begin
    resp_valid = (state == ST_FETCH_WAIT) ? ifu_resp_valid : lsu_resp_valid;
    resp_err   = (state == ST_FETCH_WAIT) ? ifu_resp_err   : lsu_resp_err;
    to_nxt     = (to_cnt == TO_MAX) ? to_cnt : to_cnt + TO_W'(1);
    to_expired = (TIMEOUT_CYCLES != 0) && (to_nxt == TO_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      to_cnt  <= '0;
      bus_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_FETCH_REQ;
        ST_FETCH_REQ: begin
          if (ifu_req_ready) begin
            state  <= ST_FETCH_WAIT;
            to_cnt <= '0;
          end
        end
        ST_MEM_REQ: begin
          if (lsu_req_ready) begin
            state  <= ST_MEM_WAIT;
            to_cnt <= '0;
          end
        end
        ST_FETCH_WAIT, ST_MEM_WAIT: begin
          if (resp_valid) begin
            if (resp_err) begin
              state   <= ST_HALT;
              bus_err <= 1'b1;
            end else begin
              state <= (state == ST_FETCH_WAIT) ? ST_EXEC : ST_WB;
            end
          end else begin
            to_cnt <= to_nxt;
            if (to_expired) begin
              state   <= ST_HALT;
              bus_err <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (dec_halt) begin
            state <= ST_HALT;
          end else if (dec_mem_rd_en && dec_mem_wr_en) begin
            state   <= ST_HALT;
            bus_err <= 1'b1;
          end else if (dec_mem_rd_en || dec_mem_wr_en) begin
            state <= ST_MEM_REQ;
          end else begin
            state <= ST_WB;
          end
        end
        ST_WB:   state <= ST_FETCH_REQ;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_HALT;
      endcase
    end
  end

  // The IR capture strobe must fire in the response cycle itself so the
  // decoder sees the new word in EXEC; it is therefore gated by the response.
  always_comb begin
    ifu_req_valid = (state == ST_FETCH_REQ);
    lsu_req_valid = (state == ST_MEM_REQ);
    inst_latch_en = (state == ST_FETCH_WAIT) && ifu_resp_valid && !ifu_resp_err;
    pc_we         = (state == ST_WB);
    rf_we         = (state == ST_WB) && dec_w_en;
    csr_we        = (state == ST_WB) && dec_w_csr_en;
    halted        = (state == ST_HALT);
    state_o       = state;
  end

`ifdef CTRL_PERF_CNT_EN
  core_seq_perf u_perf (
    .clk            (clk),
    .rst            (rst),
    .state          (state),
    .wb_pulse       (pc_we),
    .perf_cycle     (perf_cycle),
    .perf_instret   (perf_instret),
    .perf_mem_stall (perf_mem_stall)
  );
`else
  assign perf_cycle     = '0;
  assign perf_instret   = '0;
  assign perf_mem_stall = '0;
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Self-checking bench for core_seq_ctrl: directed vector table, corner-case
// sequences and randomized instructions against a transaction-level model.
module tb_core_seq_ctrl;
  import core_ctrl_pkg::*;

  localparam int TO = 4;
`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err, inst_latch_en;
  logic dec_mem_rd_en, dec_mem_wr_en, dec_w_en, dec_w_csr_en, dec_halt;
  logic lsu_req_valid, lsu_req_ready, lsu_resp_valid, lsu_resp_err;
  logic rf_we, csr_we, pc_we, halted, bus_err;
  logic [2:0]  state_o;
  logic [63:0] perf_cycle, perf_instret;
  logic [31:0] perf_mem_stall;

  always #5 clk = ~clk;

  core_seq_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_err(ifu_resp_err),
    .inst_latch_en(inst_latch_en),
    .dec_mem_rd_en(dec_mem_rd_en), .dec_mem_wr_en(dec_mem_wr_en),
    .dec_w_en(dec_w_en), .dec_w_csr_en(dec_w_csr_en), .dec_halt(dec_halt),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_err(lsu_resp_err),
    .rf_we(rf_we), .csr_we(csr_we), .pc_we(pc_we), .halted(halted),
    .bus_err(bus_err), .state_o(state_o),
    .perf_cycle(perf_cycle), .perf_instret(perf_instret),
    .perf_mem_stall(perf_mem_stall)
  );

  // ifu/lsu = {req_ready, resp_valid, resp_err}; dec = {rd, wr, w, csr, halt}
  // outs = {ifu_req, latch, lsu_req, rf_we, csr_we, pc_we, halted, bus_err}
  typedef struct packed {
    logic [2:0] ifu;
    logic [2:0] lsu;
    logic [4:0] dec;
    logic [2:0] st;
    logic [7:0] outs;
  } vec_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  vec_t        q[$];
  bit          m_err;
  logic [63:0] m_cyc, m_ret;
  logic [31:0] m_stall;

  function automatic vec_t mk(input logic [2:0] ifu, input logic [2:0] lsu,
                              input logic [4:0] dec, input logic [2:0] st,
                              input logic [7:0] outs);
    return {ifu, lsu, dec, st, outs};
  endfunction

  function automatic vec_t noise();
    vec_t r;
    r.ifu  = 3'($urandom);
    r.lsu  = 3'($urandom);
    r.dec  = 5'($urandom);
    r.st   = '0;
    r.outs = '0;
    return r;
  endfunction

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [159:0] ctrl_now();
    return 160'({state_o, ifu_req_valid, inst_latch_en, lsu_req_valid,
                 rf_we, csr_we, pc_we, halted, bus_err});
  endfunction

  function automatic logic [159:0] perf_now();
    return {perf_cycle, perf_instret, perf_mem_stall};
  endfunction

  function automatic logic [159:0] perf_exp();
    return {m_cyc, m_ret, m_stall} & {160{PERF_EN}};
  endfunction

  // Expected outputs follow from the state a cycle is in plus the inputs it sees.
  task automatic push(input logic [2:0] st, input vec_t r);
    logic wb;
    r.st = st;
    wb = (st == 3'd6);
    r.outs = {st == 3'd1, (st == 3'd2) && r.ifu[1] && !r.ifu[0], st == 3'd4,
              wb && r.dec[2], wb && r.dec[1], wb, st == 3'd7, m_err};
    q.push_back(r);
  endtask

  task automatic apply(input vec_t r);
    {ifu_req_ready, ifu_resp_valid, ifu_resp_err} = r.ifu;
    {lsu_req_ready, lsu_resp_valid, lsu_resp_err} = r.lsu;
    {dec_mem_rd_en, dec_mem_wr_en, dec_w_en, dec_w_csr_en, dec_halt} = r.dec;
    @(negedge clk);
    check("ctrl", ctrl_now(), 160'({r.st, r.outs}));
    check("perf", perf_now(), perf_exp());
    @(posedge clk);
    #1;
    m_cyc   += 64'((r.st != 3'd0) && (r.st != 3'd7));
    m_ret   += 64'(r.st == 3'd6);
    m_stall += 32'((r.st == 3'd4) || (r.st == 3'd5));
  endtask

  task automatic run_q();
    while (q.size() != 0) apply(q.pop_front());
  endtask

  // Leaves the bench just after the edge that moves IDLE to FETCH_REQ.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_ctrl", ctrl_now(), '0);
    check("rst_perf", perf_now(), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_err = 1'b0; m_cyc = '0; m_ret = '0; m_stall = '0;
    push(3'd0, noise());
    run_q();
  endtask

  task automatic halt_tail();
    for (int i = 0; i < 3; i++) push(3'd7, noise());
  endtask

  // One request/response phase: nr not-ready cycles, response in wait cycle nd.
  task automatic gen_bus(input logic [2:0] req_st, input bit is_mem, input bit clean,
                         output bit fail);
    int unsigned nr, nd;
    bit   err;
    vec_t r;
    logic [2:0] b;
    nr  = clean ? $urandom_range(0, 1) : $urandom_range(0, 3);
    nd  = clean ? $urandom_range(1, 2) : $urandom_range(1, TO + 1);
    err = clean ? 1'b0 : ($urandom_range(0, 11) == 0);
    for (int unsigned i = 0; i <= nr; i++) begin
      r = noise();
      b = is_mem ? r.lsu : r.ifu;
      b[2] = (i == nr);
      if (is_mem) r.lsu = b; else r.ifu = b;
      push(req_st, r);
    end
    for (int unsigned i = 1; i <= nd && i <= TO; i++) begin
      r = noise();
      b = is_mem ? r.lsu : r.ifu;
      b[1] = (i == nd);
      if (i == nd) b[0] = err;
      if (is_mem) r.lsu = b; else r.ifu = b;
      push(req_st + 3'd1, r);
    end
    fail = err || (nd > TO);
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 halt, 4 illegal
  task automatic gen_instr(input int unsigned kind, input bit clean, output bit stop);
    bit   fail;
    logic w, c;
    logic [4:0] dec;
    vec_t r;
    w = 1'($urandom);
    c = 1'($urandom);
    stop = 1'b1;
    gen_bus(3'd1, 1'b0, clean, fail);
    if (fail) begin
      m_err = 1'b1;
      halt_tail();
      return;
    end
    case (kind)
      0:       dec = {2'b00, w, c, 1'b0};
      1:       dec = {2'b10, w, c, 1'b0};
      2:       dec = {2'b01, w, c, 1'b0};
      3:       dec = {2'($urandom), w, c, 1'b1};
      default: dec = {2'b11, w, c, 1'b0};
    endcase
    r = noise(); r.dec = dec; push(3'd3, r);
    if (kind >= 3) begin
      if (kind == 4) m_err = 1'b1;
      halt_tail();
      return;
    end
    if (kind != 0) begin
      gen_bus(3'd4, 1'b1, clean, fail);
      if (fail) begin
        m_err = 1'b1;
        halt_tail();
        return;
      end
    end
    r = noise(); r.dec = dec; push(3'd6, r);
    stop = 1'b0;
  endtask

  vec_t tbl [22];

  initial begin
    vec_t        r;
    bit          stop;
    int unsigned k;

    tbl = '{
      // ALU, one-cycle response
      mk(3'b100, 3'b011, 5'b11111, 3'd1, 8'b1000_0000),
      mk(3'b010, 3'b000, 5'b00000, 3'd2, 8'b0100_0000),
      mk(3'b000, 3'b000, 5'b00100, 3'd3, 8'b0000_0000),
      mk(3'b000, 3'b000, 5'b00100, 3'd6, 8'b0001_0100),
      // load: fetch waits a cycle, lsu not ready for 3 cycles, response after 2
      mk(3'b100, 3'b000, 5'b00100, 3'd1, 8'b1000_0000),
      mk(3'b001, 3'b000, 5'b00000, 3'd2, 8'b0000_0000),
      mk(3'b010, 3'b000, 5'b00000, 3'd2, 8'b0100_0000),
      mk(3'b000, 3'b000, 5'b10100, 3'd3, 8'b0000_0000),
      mk(3'b000, 3'b010, 5'b10100, 3'd4, 8'b0010_0000),
      mk(3'b000, 3'b000, 5'b10100, 3'd4, 8'b0010_0000),
      mk(3'b000, 3'b000, 5'b10100, 3'd4, 8'b0010_0000),
      mk(3'b000, 3'b100, 5'b10100, 3'd4, 8'b0010_0000),
      mk(3'b000, 3'b001, 5'b10100, 3'd5, 8'b0000_0000),
      mk(3'b000, 3'b010, 5'b10100, 3'd5, 8'b0000_0000),
      mk(3'b000, 3'b000, 5'b10100, 3'd6, 8'b0001_0100),
      // store with CSR write only
      mk(3'b100, 3'b000, 5'b00000, 3'd1, 8'b1000_0000),
      mk(3'b010, 3'b000, 5'b00000, 3'd2, 8'b0100_0000),
      mk(3'b000, 3'b000, 5'b01010, 3'd3, 8'b0000_0000),
      mk(3'b000, 3'b100, 5'b01010, 3'd4, 8'b0010_0000),
      mk(3'b000, 3'b010, 5'b01010, 3'd5, 8'b0000_0000),
      mk(3'b000, 3'b000, 5'b01010, 3'd6, 8'b0000_1100),
      mk(3'b000, 3'b000, 5'b00000, 3'd1, 8'b1000_0000)
    };

    {ifu_req_ready, ifu_resp_valid, ifu_resp_err} = '0;
    {lsu_req_ready, lsu_resp_valid, lsu_resp_err} = '0;
    {dec_mem_rd_en, dec_mem_wr_en, dec_w_en, dec_w_csr_en, dec_halt} = '0;
    #1;
    do_reset();
    for (int i = 0; i < 22; i++) apply(tbl[i]);

    // fetch timeout: no response for TO wait cycles
    do_reset();
    r = noise(); r.ifu[2] = 1'b1; push(3'd1, r);
    for (int i = 0; i < TO; i++) begin
      r = noise(); r.ifu[1] = 1'b0; push(3'd2, r);
    end
    m_err = 1'b1;
    halt_tail();
    run_q();

    // response in the expiry cycle beats the timeout
    do_reset();
    r = noise(); r.ifu[2] = 1'b1; push(3'd1, r);
    for (int i = 1; i <= TO; i++) begin
      r = noise(); r.ifu[1] = (i == TO);
      if (i == TO) r.ifu[0] = 1'b0;
      push(3'd2, r);
    end
    r = noise(); r.dec = 5'b00100; push(3'd3, r);
    r = noise(); r.dec = 5'b00100; push(3'd6, r);
    run_q();

    // decoded halt, then illegal rd+wr decode
    do_reset();
    gen_instr(3, 1'b1, stop);
    run_q();
    do_reset();
    gen_instr(4, 1'b1, stop);
    run_q();

    // reset asserted while waiting for a load response
    do_reset();
    r = noise(); r.ifu[2] = 1'b1; push(3'd1, r);
    r = noise(); r.ifu[1:0] = 2'b10; push(3'd2, r);
    r = noise(); r.dec = 5'b10100; push(3'd3, r);
    r = noise(); r.lsu[2] = 1'b1; push(3'd4, r);
    run_q();
    {lsu_req_ready, lsu_resp_valid, lsu_resp_err} = '0;
    check("mem_wait", 160'(state_o), 160'(5));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ctrl", ctrl_now(), '0);
    check("async_rst_perf", perf_now(), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_err = 1'b0; m_cyc = '0; m_ret = '0; m_stall = '0;
    push(3'd0, noise());
    r = noise(); r.ifu[2] = 1'b0; push(3'd1, r);
    run_q();

    // randomized instruction stream
    do_reset();
    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 9);
      gen_instr((k < 4) ? 0 : (k < 6) ? 1 : (k < 8) ? 2 : (k == 8) ? 3 : 4, 1'b0, stop);
      run_q();
      if (stop) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
